// File: rtl/hazard_control_unit.sv
// hazard_control_unit
// Stall/flush controller for the 5-stage RV32 pipeline. It resolves the hazards
// that EX-stage forwarding cannot cover: data-memory wait states, multi-cycle
// MUL/DIV occupancy, taken-branch squash and the one-bubble load-use case.
// Stage controls are a zero-cycle combinational function of the inputs, the
// MUL/DIV busy state and the sticky done_pend flag.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is
// defined. Otherwise the counter outputs read zero and perf_clear is ignored.
module hazard_control_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [4:0]       rd_ex,
  input  logic             mem_read_ex,
  input  logic             branch_taken_ex,
  input  logic             mdu_start_ex,
  input  logic             mdu_done,
  input  logic             dmem_req_mem,
  input  logic             dmem_ready,
  input  logic             perf_clear,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] load_use_stalls,
  output logic [CNT_W-1:0] branch_flushes
);

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } state_t;

  state_t state;
  logic   done_pend;

  logic mem_stall;
  logic mdu_stall;
  logic load_use;

  // The memory wait freezes the whole pipeline, so it outranks every other cause.
  assign mem_stall = dmem_req_mem & ~dmem_ready;

  // A done that was latched during a memory wait releases the MUL/DIV stall at once.
  assign mdu_stall = ((state == MDU_BUSY) & ~mdu_done & ~done_pend) |
                     ((state == RUN) & mdu_start_ex & ~mdu_done);

  // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
  assign load_use = mem_read_ex & (rd_ex != 5'd0) &
                    ((rs1_used_id & (rs1_id == rd_ex)) |
                     (rs2_used_id & (rs2_id == rd_ex)));

  // Priority decode of the stage enables and flushes, with reset forcing the pipe to NOPs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (mem_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (mdu_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (branch_taken_ex) begin
      // The PC keeps loading the branch target. The squashed ID instruction cannot cause a load-use stall.
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (load_use) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_flush  = 1'b1;
    end
  end

  // MUL/DIV occupancy tracking. It is frozen during memory waits, but a done that arrives then is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (!rst_n) begin
      state     <= RUN;
      done_pend <= 1'b0;
    end else if (mem_stall) begin
      if (mdu_done) done_pend <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (mdu_start_ex && !mdu_done) state <= MDU_BUSY;
        end
        MDU_BUSY: begin
          if (mdu_done || done_pend) begin
            state     <= RUN;
            done_pend <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] lu_q;
  logic [CNT_W-1:0] br_q;
  logic             lu_active;
  logic             br_active;

  // The branch and load-use counters count only when their term is the winning cause.
  assign br_active = ~mem_stall & ~mdu_stall & branch_taken_ex;
  assign lu_active = ~mem_stall & ~mdu_stall & ~branch_taken_ex & load_use;

  // Wrapping event counters. A clear wins over any increment on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      lu_q    <= '0;
      br_q    <= '0;
    end else if (perf_clear) begin
      stall_q <= '0;
      lu_q    <= '0;
      br_q    <= '0;
    end else begin
      if (!pc_en)    stall_q <= stall_q + CNT_W'(1);
      if (lu_active) lu_q    <= lu_q + CNT_W'(1);
      if (br_active) br_q    <= br_q + CNT_W'(1);
    end
  end

  assign stall_cycles    = stall_q;
  assign load_use_stalls = lu_q;
  assign branch_flushes  = br_q;
`else
  logic unused_perf_clear;
  assign unused_perf_clear = perf_clear;

  assign stall_cycles    = '0;
  assign load_use_stalls = '0;
  assign branch_flushes  = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit
// Directed scenarios from the hazard rules plus a randomized run against a
// cause-priority reference model. The counters are narrowed to 8 bits so that
// wrap-around can be reached. Counter expectations read zero unless
// HAZARD_PERF_CNT_EN is defined.
module tb_hazard_control_unit;

  localparam int CNT_W = 8;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Packed stage controls: {pc, if_id, id_ex, ex_mem enables, if_id, id_ex, ex_mem, mem_wb flushes}.
  localparam logic [7:0] CTL_RUN = 8'b1111_0000;
  localparam logic [7:0] CTL_RST = 8'b0000_1111;
  localparam logic [7:0] CTL_MEM = 8'b0000_0001;
  localparam logic [7:0] CTL_MDU = 8'b0001_0010;
  localparam logic [7:0] CTL_BR  = 8'b1111_1100;
  localparam logic [7:0] CTL_LU  = 8'b0011_0100;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic rs1_used_id, rs2_used_id, mem_read_ex, branch_taken_ex;
  logic mdu_start_ex, mdu_done, dmem_req_mem, dmem_ready, perf_clear;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [CNT_W-1:0] stall_cycles, load_use_stalls, branch_flushes;
  logic [7:0] ctl;

  int n_cmp = 0;
  int n_err = 0;

  hazard_control_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex),
    .mdu_start_ex(mdu_start_ex), .mdu_done(mdu_done),
    .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready), .perf_clear(perf_clear),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .stall_cycles(stall_cycles), .load_use_stalls(load_use_stalls),
    .branch_flushes(branch_flushes)
  );

  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

  always #5 clk = ~clk;

  // Expected counter value: the count itself when counters are built, zero otherwise.
  function automatic logic [CNT_W-1:0] ec(input int v);
    return PERF ? CNT_W'(v) : '0;
  endfunction

  task automatic idle();
    rs1_id = 5'd0; rs2_id = 5'd0; rs1_used_id = 1'b0; rs2_used_id = 1'b0;
    rd_ex = 5'd0; mem_read_ex = 1'b0; branch_taken_ex = 1'b0;
    mdu_start_ex = 1'b0; mdu_done = 1'b0;
    dmem_req_mem = 1'b0; dmem_ready = 1'b1; perf_clear = 1'b0;
  endtask

  // Advance to just after the next rising edge. All tasks start and end here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counters();
    idle();
    perf_clear = 1'b1;
    tick();
    perf_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #3;
    if (ctl !== CTL_RST) begin n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, CTL_RST); end
    n_cmp++;
    if (stall_cycles !== '0 || load_use_stalls !== '0 || branch_flushes !== '0) begin
      n_err++; $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0", stall_cycles, load_use_stalls, branch_flushes);
    end
    n_cmp++;
    tick();
    rst_n = 1'b1;
    #2;
    if (ctl !== CTL_RUN) begin n_err++; $display("FAIL reset_release: got %b want %b", ctl, CTL_RUN); end
    n_cmp++;
    tick();
  endtask

  task automatic test_load_use();
    clear_counters();
    rd_ex = 5'd5; mem_read_ex = 1'b1; rs1_id = 5'd5; rs1_used_id = 1'b1;
    #2;
    if (ctl !== CTL_LU) begin n_err++; $display("FAIL lu_rs1: got %b want %b", ctl, CTL_LU); end
    n_cmp++;
    tick();
    idle();
    #2;
    if (ctl !== CTL_RUN) begin n_err++; $display("FAIL lu_one_bubble: got %b want %b", ctl, CTL_RUN); end
    n_cmp++;
    if (load_use_stalls !== ec(1)) begin n_err++; $display("FAIL lu_count: got %0d want %0d", load_use_stalls, ec(1)); end
    n_cmp++;
    if (stall_cycles !== ec(1)) begin n_err++; $display("FAIL lu_stall_count: got %0d want %0d", stall_cycles, ec(1)); end
    n_cmp++;
    tick();
    rd_ex = 5'd0; mem_read_ex = 1'b1; rs1_id = 5'd0; rs1_used_id = 1'b1;
    #2;
    if (ctl !== CTL_RUN) begin n_err++; $display("FAIL lu_x0: got %b want %b", ctl, CTL_RUN); end
    n_cmp++;
    tick();
    idle();
    rd_ex = 5'd7; mem_read_ex = 1'b1; rs1_id = 5'd7; rs2_id = 5'd7; rs2_used_id = 1'b1;
    #2;
    if (ctl !== CTL_LU) begin n_err++; $display("FAIL lu_rs2: got %b want %b", ctl, CTL_LU); end
    n_cmp++;
    tick();
    rs2_used_id = 1'b0;
    #2;
    if (ctl !== CTL_RUN) begin n_err++; $display("FAIL lu_unused_src: got %b want %b", ctl, CTL_RUN); end
    n_cmp++;
    tick();
    idle();
  endtask

  task automatic test_branch_vs_load_use();
    clear_counters();
    branch_taken_ex = 1'b1;
    rd_ex = 5'd9; mem_read_ex = 1'b1; rs1_id = 5'd9; rs1_used_id = 1'b1;
    #2;
    if (ctl !== CTL_BR) begin n_err++; $display("FAIL br_over_lu: got %b want %b", ctl, CTL_BR); end
    n_cmp++;
    tick();
    idle();
    #2;
    if (branch_flushes !== ec(1)) begin n_err++; $display("FAIL br_count: got %0d want %0d", branch_flushes, ec(1)); end
    n_cmp++;
    if (load_use_stalls !== ec(0)) begin n_err++; $display("FAIL br_lu_count: got %0d want %0d", load_use_stalls, ec(0)); end
    n_cmp++;
    tick();
  endtask

  task automatic test_mdu_busy();
    clear_counters();
    mdu_start_ex = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      if (ctl !== CTL_MDU) begin n_err++; $display("FAIL mdu_stall_c%0d: got %b want %b", i, ctl, CTL_MDU); end
      n_cmp++;
      tick();
      mdu_start_ex = 1'b0;
    end
    mdu_done = 1'b1;
    #2;
    if (ctl !== CTL_RUN) begin n_err++; $display("FAIL mdu_done_release: got %b want %b", ctl, CTL_RUN); end
    n_cmp++;
    tick();
    idle();
    #2;
    if (stall_cycles !== ec(4)) begin n_err++; $display("FAIL mdu_stall_count: got %0d want %0d", stall_cycles, ec(4)); end
    n_cmp++;
    tick();
    mdu_start_ex = 1'b1; mdu_done = 1'b1;
    #2;
    if (ctl !== CTL_RUN) begin n_err++; $display("FAIL mdu_same_cycle: got %b want %b", ctl, CTL_RUN); end
    n_cmp++;
    tick();
    idle();
    #2;
    if (ctl !== CTL_RUN) begin n_err++; $display("FAIL mdu_same_cycle_next: got %b want %b", ctl, CTL_RUN); end
    n_cmp++;
    if (stall_cycles !== ec(4)) begin n_err++; $display("FAIL mdu_same_cycle_count: got %0d want %0d", stall_cycles, ec(4)); end
    n_cmp++;
    tick();
  endtask

  task automatic test_mem_wait();
    clear_counters();
    for (int i = 0; i < 3; i++) begin
      dmem_req_mem = 1'b1; dmem_ready = 1'b0;
      branch_taken_ex = (i == 1);
      #2;
      if (ctl !== CTL_MEM) begin n_err++; $display("FAIL mem_wait_c%0d: got %b want %b", i, ctl, CTL_MEM); end
      n_cmp++;
      tick();
    end
    idle();
    dmem_req_mem = 1'b1; dmem_ready = 1'b1;
    #2;
    if (ctl !== CTL_RUN) begin n_err++; $display("FAIL mem_ready: got %b want %b", ctl, CTL_RUN); end
    n_cmp++;
    if (stall_cycles !== ec(3)) begin n_err++; $display("FAIL mem_stall_count: got %0d want %0d", stall_cycles, ec(3)); end
    n_cmp++;
    if (branch_flushes !== ec(0)) begin n_err++; $display("FAIL mem_br_count: got %0d want %0d", branch_flushes, ec(0)); end
    n_cmp++;
    tick();
    idle();
  endtask

  task automatic test_overlap();
    clear_counters();
    mdu_start_ex = 1'b1;
    #2;
    if (ctl !== CTL_MDU) begin n_err++; $display("FAIL ovl_start: got %b want %b", ctl, CTL_MDU); end
    n_cmp++;
    tick();
    mdu_start_ex = 1'b0;
    #2;
    if (ctl !== CTL_MDU) begin n_err++; $display("FAIL ovl_busy: got %b want %b", ctl, CTL_MDU); end
    n_cmp++;
    tick();
    dmem_req_mem = 1'b1; dmem_ready = 1'b0; mdu_done = 1'b1;
    #2;
    if (ctl !== CTL_MEM) begin n_err++; $display("FAIL ovl_mem_done: got %b want %b", ctl, CTL_MEM); end
    n_cmp++;
    tick();
    mdu_done = 1'b0;
    #2;
    if (ctl !== CTL_MEM) begin n_err++; $display("FAIL ovl_mem2: got %b want %b", ctl, CTL_MEM); end
    n_cmp++;
    tick();
    idle();
    #2;
    if (ctl !== CTL_RUN) begin n_err++; $display("FAIL ovl_pend_release: got %b want %b", ctl, CTL_RUN); end
    n_cmp++;
    tick();
    #2;
    if (ctl !== CTL_RUN) begin n_err++; $display("FAIL ovl_no_extra: got %b want %b", ctl, CTL_RUN); end
    n_cmp++;
    if (stall_cycles !== ec(4)) begin n_err++; $display("FAIL ovl_stall_count: got %0d want %0d", stall_cycles, ec(4)); end
    n_cmp++;
    tick();
    // A fresh operation must stall again: state is back in RUN with nothing pending.
    mdu_start_ex = 1'b1;
    tick();
    mdu_start_ex = 1'b0;
    #2;
    if (ctl !== CTL_MDU) begin n_err++; $display("FAIL ovl_restart: got %b want %b", ctl, CTL_MDU); end
    n_cmp++;
    tick();
    mdu_done = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset_mid_stall();
    mdu_start_ex = 1'b1;
    tick();
    mdu_start_ex = 1'b0;
    dmem_req_mem = 1'b1; dmem_ready = 1'b0; mdu_done = 1'b1;
    tick();
    idle();
    rst_n = 1'b0;
    #2;
    if (ctl !== CTL_RST) begin n_err++; $display("FAIL rst_mid_ctl: got %b want %b", ctl, CTL_RST); end
    n_cmp++;
    if (stall_cycles !== '0) begin n_err++; $display("FAIL rst_mid_cnt: got %0d want 0", stall_cycles); end
    n_cmp++;
    tick();
    rst_n = 1'b1;
    #2;
    if (ctl !== CTL_RUN) begin n_err++; $display("FAIL rst_mid_run: got %b want %b", ctl, CTL_RUN); end
    n_cmp++;
    tick();
    // The done latched before reset must be gone: a new operation stalls past its first cycle.
    mdu_start_ex = 1'b1;
    tick();
    mdu_start_ex = 1'b0;
    #2;
    if (ctl !== CTL_MDU) begin n_err++; $display("FAIL rst_pend_discard: got %b want %b", ctl, CTL_MDU); end
    n_cmp++;
    tick();
    mdu_done = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_counter_wrap_clear();
    clear_counters();
    dmem_req_mem = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 255; i++) tick();
    idle();
    #2;
    if (stall_cycles !== ec(255)) begin n_err++; $display("FAIL wrap_max: got %0d want %0d", stall_cycles, ec(255)); end
    n_cmp++;
    dmem_req_mem = 1'b1; dmem_ready = 1'b0;
    tick();
    idle();
    #2;
    if (stall_cycles !== ec(0)) begin n_err++; $display("FAIL wrap_zero: got %0d want %0d", stall_cycles, ec(0)); end
    n_cmp++;
    branch_taken_ex = 1'b1;
    tick();
    idle();
    rd_ex = 5'd3; mem_read_ex = 1'b1; rs2_id = 5'd3; rs2_used_id = 1'b1;
    tick();
    idle();
    #2;
    if (branch_flushes !== ec(1) || load_use_stalls !== ec(1) || stall_cycles !== ec(1)) begin
      n_err++; $display("FAIL pre_clear_cnt: got %0d/%0d/%0d want %0d/%0d/%0d", branch_flushes,
                        load_use_stalls, stall_cycles, ec(1), ec(1), ec(1));
    end
    n_cmp++;
    perf_clear = 1'b1; dmem_req_mem = 1'b1; dmem_ready = 1'b0;
    tick();
    idle();
    #2;
    if (branch_flushes !== '0 || load_use_stalls !== '0 || stall_cycles !== '0) begin
      n_err++; $display("FAIL perf_clear: got %0d/%0d/%0d want 0/0/0", branch_flushes, load_use_stalls, stall_cycles);
    end
    n_cmp++;
    tick();
  endtask

  // Randomized traffic against a model that ranks the hazard causes and tracks MUL/DIV in flight.
  task automatic test_random();
    bit m_busy = 1'b0;
    bit m_pend = 1'b0;
    int m_stall = 0, m_lu = 0, m_br = 0;
    int modulus = 1 << CNT_W;
    bit mem_w, mdu_w, lu_hit, rs1_hit, rs2_hit;
    logic [7:0] exp_ctl;
    rst_n = 1'b0;
    idle();
    #2;
    rst_n = 1'b1;
    tick();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rs1_id          = 5'($urandom_range(0, 3));
      rs2_id          = 5'($urandom_range(0, 3));
      rd_ex           = 5'($urandom_range(0, 3));
      rs1_used_id     = 1'($urandom_range(0, 1));
      rs2_used_id     = 1'($urandom_range(0, 1));
      mem_read_ex     = 1'($urandom_range(0, 1));
      branch_taken_ex = ($urandom_range(0, 4) == 0);
      mdu_start_ex    = ($urandom_range(0, 6) == 0);
      mdu_done        = ($urandom_range(0, 6) == 0);
      dmem_req_mem    = ($urandom_range(0, 2) == 0);
      dmem_ready      = 1'($urandom_range(0, 1));
      perf_clear      = ($urandom_range(0, 40) == 0);
      #2;
      mem_w   = dmem_req_mem && !dmem_ready;
      mdu_w   = m_busy ? (!mdu_done && !m_pend) : (mdu_start_ex && !mdu_done);
      rs1_hit = rs1_used_id && rs1_id == rd_ex;
      rs2_hit = rs2_used_id && rs2_id == rd_ex;
      lu_hit  = mem_read_ex && rd_ex != 0 && (rs1_hit || rs2_hit);
      if (mem_w)                exp_ctl = CTL_MEM;
      else if (mdu_w)           exp_ctl = CTL_MDU;
      else if (branch_taken_ex) exp_ctl = CTL_BR;
      else if (lu_hit)          exp_ctl = CTL_LU;
      else                      exp_ctl = CTL_RUN;
      if (ctl !== exp_ctl) begin n_err++; $display("FAIL rand_ctl@%0d: got %b want %b", cyc, ctl, exp_ctl); end
      n_cmp++;
      if (stall_cycles !== ec(m_stall)) begin n_err++; $display("FAIL rand_stall@%0d: got %0d want %0d", cyc, stall_cycles, ec(m_stall)); end
      n_cmp++;
      if (load_use_stalls !== ec(m_lu)) begin n_err++; $display("FAIL rand_lu@%0d: got %0d want %0d", cyc, load_use_stalls, ec(m_lu)); end
      n_cmp++;
      if (branch_flushes !== ec(m_br)) begin n_err++; $display("FAIL rand_br@%0d: got %0d want %0d", cyc, branch_flushes, ec(m_br)); end
      n_cmp++;
      if (perf_clear) begin
        m_stall = 0; m_lu = 0; m_br = 0;
      end else begin
        if (exp_ctl[7] == 1'b0)  m_stall = (m_stall + 1) % modulus;
        if (exp_ctl == CTL_LU)   m_lu    = (m_lu + 1) % modulus;
        if (exp_ctl == CTL_BR)   m_br    = (m_br + 1) % modulus;
      end
      if (mem_w) begin
        if (mdu_done) m_pend = 1'b1;
      end else if (m_busy) begin
        if (mdu_done || m_pend) begin m_busy = 1'b0; m_pend = 1'b0; end
      end else if (mdu_start_ex && !mdu_done) begin
        m_busy = 1'b1;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_vs_load_use();
    test_mdu_busy();
    test_mem_wait();
    test_overlap();
    test_reset_mid_stall();
    test_counter_wrap_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
